// File: rtl/mux_lfmr.sv
// mux_lfmr: fixed-latency pipelined N:1 multiplexer.
// The INPUT_COUNT channels are reduced through a radix-R tree of register
// levels. Each level consumes its own slice of the select value, taken from a
// select pipeline so that back-to-back transfers never see each other's select.
// Plain delay stages top the latency up to exactly LATENCY clocks.
module mux_lfmr #(
   parameter int WIDTH       = 1,
   parameter int INPUT_COUNT = 2,
   parameter int LATENCY     = 1,
   parameter int PRINT       = 0,
   localparam int SEL_W      = ($clog2(INPUT_COUNT) > 1) ? $clog2(INPUT_COUNT) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [WIDTH*INPUT_COUNT-1:0] in,
   input  logic [SEL_W-1:0]             sel,
   input  logic                         in_valid,
   output logic [WIDTH-1:0]             out,
   output logic [SEL_W-1:0]             out_sel,
   output logic                         out_valid
);

   // R^LATENCY >= N holds exactly when B*LATENCY >= clog2(N), because R is a
   // power of two; the same argument gives the level count D.
   localparam int LOG_N = ($clog2(INPUT_COUNT) > 1) ? $clog2(INPUT_COUNT) : 1;
   localparam int B_RAW = (LOG_N + LATENCY - 1) / LATENCY;
   localparam int B     = (B_RAW > 1) ? B_RAW : 1;
   localparam int R     = 1 << B;
   localparam int D     = (LOG_N + B - 1) / B;
   localparam int PAD   = LATENCY - D;

   // Entry count of tree level k; level -1 is the raw input vector.
   function automatic int levelCount(input int k);
      int cnt;
      cnt = INPUT_COUNT;
      for (int i = 0; i <= k; i++) begin
         cnt = (cnt + R - 1) / R;
      end
      return cnt;
   endfunction

   if (INPUT_COUNT < 2 || LATENCY < 1) begin : gBadParam
      $error("mux_lfmr: INPUT_COUNT must be >= 2 and LATENCY >= 1");
   end

   if (PRINT != 0) begin : gPrint
      $info("mux_lfmr: R=%0d B=%0d D=%0d pad stages=%0d", R, B, D, PAD);
   end

   logic [SEL_W-1:0] selPipe_q [LATENCY];
   logic [LATENCY-1:0] validPipe_q;
   logic [WIDTH-1:0] treeOut;

   // Select and valid travel alongside the data; stage i holds the value
   // captured i+1 clocks ago, so tree level k reads stage k-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            selPipe_q[i] <= '0;
         end
         validPipe_q <= '0;
      end else begin
         selPipe_q[0]   <= sel;
         validPipe_q[0] <= in_valid;
         for (int i = 1; i < LATENCY; i++) begin
            selPipe_q[i]   <= selPipe_q[i-1];
            validPipe_q[i] <= validPipe_q[i-1];
         end
      end
   end

   assign out_sel   = selPipe_q[LATENCY-1];
   assign out_valid = validPipe_q[LATENCY-1];

   for (genvar k = 0; k < D; k++) begin : gLvl
      localparam int PREV = levelCount(k - 1);
      localparam int CNT  = levelCount(k);

      logic [PREV*WIDTH-1:0] src;
      logic [B-1:0]          digit;
      logic [CNT*WIDTH-1:0]  data_d;
      logic [CNT*WIDTH-1:0]  data_q;

      if (k == 0) begin : gFirst
         assign src = in;
      end else begin : gNext
         assign src = gLvl[k-1].data_q;
      end

      // Digit bits beyond the select width read as zero.
      for (genvar b = 0; b < B; b++) begin : gDigit
         if (k*B + b >= SEL_W) begin : gZero
            assign digit[b] = 1'b0;
         end else if (k == 0) begin : gLive
            assign digit[b] = sel[k*B + b];
         end else begin : gDelayed
            assign digit[b] = selPipe_q[k-1][k*B + b];
         end
      end

      if (PRINT != 0) begin : gPrintLvl
         $info("mux_lfmr: level %0d has %0d entries", k, CNT);
      end

      // Each group of R entries picks one member by digit; positions past the
      // end of a partial group stay zero, which makes out-of-range selects zero.
      always_comb begin
         data_d = '0;
         for (int j = 0; j < CNT; j++) begin
            for (int r = 0; r < R; r++) begin
               if (((j*R + r) < PREV) && (digit == B'(r))) begin
                  data_d[j*WIDTH +: WIDTH] = src[(j*R + r)*WIDTH +: WIDTH];
               end
            end
         end
      end

      // One register stage per tree level, loaded every clock.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q <= '0;
         end else begin
            data_q <= data_d;
         end
      end
   end

   assign treeOut = gLvl[D-1].data_q;

   if (PAD > 0) begin : gPad
      logic [WIDTH-1:0] pad_q [PAD];

      // Extra delay on the reduced data when the tree is shallower than LATENCY.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < PAD; i++) begin
               pad_q[i] <= '0;
            end
         end else begin
            pad_q[0] <= treeOut;
            for (int i = 1; i < PAD; i++) begin
               pad_q[i] <= pad_q[i-1];
            end
         end
      end

      assign out = pad_q[PAD-1];
   end else begin : gNoPad
      assign out = treeOut;
   end

endmodule

// File: tb/tb_mux_lfmr.sv
// tb_mux_lfmr: directed checks of mux_lfmr in two configurations:
// A = 8 bits, 5 inputs, latency 2 (radix 4, two levels)
// B = 8 bits, 4 inputs, latency 3 (radix 2, two levels plus one delay stage)
module tb_mux_lfmr;

   localparam int LAT_A = 2;
   localparam int LAT_B = 3;

   logic clk = 1'b0;
   logic rst_n;

   logic [39:0] inA;
   logic [2:0]  selA;
   logic        validA;
   logic [7:0]  outA;
   logic [2:0]  outSelA;
   logic        outValidA;

   logic [31:0] inB;
   logic [1:0]  selB;
   logic        validB;
   logic [7:0]  outB;
   logic [1:0]  outSelB;
   logic        outValidB;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   mux_lfmr #(.WIDTH(8), .INPUT_COUNT(5), .LATENCY(LAT_A), .PRINT(0)) dutA (
      .clk(clk), .rst_n(rst_n), .in(inA), .sel(selA), .in_valid(validA),
      .out(outA), .out_sel(outSelA), .out_valid(outValidA)
   );

   mux_lfmr #(.WIDTH(8), .INPUT_COUNT(4), .LATENCY(LAT_B), .PRINT(0)) dutB (
      .clk(clk), .rst_n(rst_n), .in(inB), .sel(selB), .in_valid(validB),
      .out(outB), .out_sel(outSelB), .out_valid(outValidB)
   );

   // Inputs change on the falling edge, well away from the sampling edge.
   task automatic applyStimulusA(input logic [2:0] s, input logic v);
      @(negedge clk);
      selA   = s;
      validA = v;
   endtask

   task automatic applyStimulusB(input logic [1:0] s, input logic v);
      @(negedge clk);
      selB   = s;
      validB = v;
   endtask

   // Outputs of both instances must read zero while reset is held.
   task automatic test_reset();
      rst_n  = 1'b0;
      selA   = 3'd0;
      validA = 1'b0;
      selB   = 2'd0;
      validB = 1'b0;
      inA    = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
      inB    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      repeat (2) @(posedge clk);
      #1;
      assertCount++; if (outA !== 8'h00) begin failCount++; $display("[TB] FAIL reset_outA: got %h expected 00", outA); end
      assertCount++; if (outSelA !== 3'd0) begin failCount++; $display("[TB] FAIL reset_outSelA: got %0d expected 0", outSelA); end
      assertCount++; if (outValidA !== 1'b0) begin failCount++; $display("[TB] FAIL reset_outValidA: got %b expected 0", outValidA); end
      assertCount++; if (outB !== 8'h00) begin failCount++; $display("[TB] FAIL reset_outB: got %h expected 00", outB); end
      assertCount++; if (outSelB !== 2'd0) begin failCount++; $display("[TB] FAIL reset_outSelB: got %0d expected 0", outSelB); end
      assertCount++; if (outValidB !== 1'b0) begin failCount++; $display("[TB] FAIL reset_outValidB: got %b expected 0", outValidB); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   // sel=4 presented after edge 0 must appear after edge 2 and not before.
   task automatic test_single_select();
      @(posedge clk); #1;
      assertCount++; if (outValidA !== 1'b0) begin failCount++; $display("[TB] FAIL single_valid_edge0: got %b expected 0", outValidA); end
      applyStimulusA(3'd4, 1'b1);
      @(posedge clk); #1;
      assertCount++; if (outValidA !== 1'b0) begin failCount++; $display("[TB] FAIL single_valid_edge1: got %b expected 0", outValidA); end
      applyStimulusA(3'd0, 1'b0);
      @(posedge clk); #1;
      assertCount++; if (outA !== 8'h44) begin failCount++; $display("[TB] FAIL single_out: got %h expected 44", outA); end
      assertCount++; if (outSelA !== 3'd4) begin failCount++; $display("[TB] FAIL single_outSel: got %0d expected 4", outSelA); end
      assertCount++; if (outValidA !== 1'b1) begin failCount++; $display("[TB] FAIL single_valid_edge2: got %b expected 1", outValidA); end
      @(posedge clk);
   endtask

   // sel 0..4 on consecutive clocks gives 00,11,22,33,44 with no gaps.
   task automatic test_sel_sweep();
      logic [2:0] selTab [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      logic [7:0] expTab [5] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      for (int c = 0; c < 5 + LAT_A - 1; c++) begin
         if (c < 5) applyStimulusA(selTab[c], 1'b1);
         else applyStimulusA(3'd0, 1'b0);
         @(posedge clk); #1;
         if (c >= LAT_A - 1) begin
            assertCount++; if (outValidA !== 1'b1) begin failCount++; $display("[TB] FAIL sweep_valid[%0d]: got %b expected 1", c-LAT_A+1, outValidA); end
            assertCount++; if (outA !== expTab[c-LAT_A+1]) begin failCount++; $display("[TB] FAIL sweep_out[%0d]: got %h expected %h", c-LAT_A+1, outA, expTab[c-LAT_A+1]); end
            assertCount++; if (outSelA !== selTab[c-LAT_A+1]) begin failCount++; $display("[TB] FAIL sweep_outSel[%0d]: got %0d expected %0d", c-LAT_A+1, outSelA, selTab[c-LAT_A+1]); end
         end
      end
      @(posedge clk);
   endtask

   // Selects past the last channel return zero, not a neighbour or a stale value.
   task automatic test_out_of_range();
      logic [2:0] selTab [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
      logic [7:0] expTab [4] = '{8'h44, 8'h00, 8'h00, 8'h00};
      for (int c = 0; c < 4 + LAT_A - 1; c++) begin
         if (c < 4) applyStimulusA(selTab[c], 1'b1);
         else applyStimulusA(3'd0, 1'b0);
         @(posedge clk); #1;
         if (c >= LAT_A - 1) begin
            assertCount++; if (outValidA !== 1'b1) begin failCount++; $display("[TB] FAIL range_valid[%0d]: got %b expected 1", c-LAT_A+1, outValidA); end
            assertCount++; if (outA !== expTab[c-LAT_A+1]) begin failCount++; $display("[TB] FAIL range_out[%0d]: got %h expected %h", c-LAT_A+1, outA, expTab[c-LAT_A+1]); end
            assertCount++; if (outSelA !== selTab[c-LAT_A+1]) begin failCount++; $display("[TB] FAIL range_outSel[%0d]: got %0d expected %0d", c-LAT_A+1, outSelA, selTab[c-LAT_A+1]); end
         end
      end
      @(posedge clk);
   endtask

   // Bubbles on in_valid reappear in the same slots on out_valid.
   task automatic test_valid_bubbles();
      logic [2:0] selTab [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4};
      logic       vldTab [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] expTab [5] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h44};
      for (int c = 0; c < 5 + LAT_A - 1; c++) begin
         if (c < 5) applyStimulusA(selTab[c], vldTab[c]);
         else applyStimulusA(3'd0, 1'b0);
         @(posedge clk); #1;
         if (c >= LAT_A - 1) begin
            assertCount++; if (outValidA !== vldTab[c-LAT_A+1]) begin failCount++; $display("[TB] FAIL bubble_valid[%0d]: got %b expected %b", c-LAT_A+1, outValidA, vldTab[c-LAT_A+1]); end
            if (vldTab[c-LAT_A+1]) begin
               assertCount++; if (outA !== expTab[c-LAT_A+1]) begin failCount++; $display("[TB] FAIL bubble_out[%0d]: got %h expected %h", c-LAT_A+1, outA, expTab[c-LAT_A+1]); end
            end
         end
      end
      @(posedge clk);
   endtask

   // A select that changes every clock must not bleed between neighbours.
   task automatic test_back_to_back();
      logic [2:0] selTab [7] = '{3'd4, 3'd0, 3'd3, 3'd1, 3'd2, 3'd6, 3'd2};
      logic [7:0] expTab [7] = '{8'h44, 8'h00, 8'h33, 8'h11, 8'h22, 8'h00, 8'h22};
      for (int c = 0; c < 7 + LAT_A - 1; c++) begin
         if (c < 7) applyStimulusA(selTab[c], 1'b1);
         else applyStimulusA(3'd0, 1'b0);
         @(posedge clk); #1;
         if (c >= LAT_A - 1) begin
            assertCount++; if (outA !== expTab[c-LAT_A+1]) begin failCount++; $display("[TB] FAIL b2b_out[%0d]: got %h expected %h", c-LAT_A+1, outA, expTab[c-LAT_A+1]); end
            assertCount++; if (outSelA !== selTab[c-LAT_A+1]) begin failCount++; $display("[TB] FAIL b2b_outSel[%0d]: got %0d expected %0d", c-LAT_A+1, outSelA, selTab[c-LAT_A+1]); end
         end
      end
      @(posedge clk);
   endtask

   // Latency 3 with one delay stage: every sel arrives after exactly edge 3.
   task automatic test_latency_pad();
      logic [7:0] chanB [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
      logic [1:0] selTab [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
      for (int s = 3; s >= 0; s--) begin
         @(posedge clk); #1;
         assertCount++; if (outValidB !== 1'b0) begin failCount++; $display("[TB] FAIL pad_valid_e0_sel%0d: got %b expected 0", s, outValidB); end
         applyStimulusB(2'(s), 1'b1);
         @(posedge clk); #1;
         assertCount++; if (outValidB !== 1'b0) begin failCount++; $display("[TB] FAIL pad_valid_e1_sel%0d: got %b expected 0", s, outValidB); end
         applyStimulusB(2'd0, 1'b0);
         @(posedge clk); #1;
         assertCount++; if (outValidB !== 1'b0) begin failCount++; $display("[TB] FAIL pad_valid_e2_sel%0d: got %b expected 0", s, outValidB); end
         @(posedge clk); #1;
         assertCount++; if (outValidB !== 1'b1) begin failCount++; $display("[TB] FAIL pad_valid_e3_sel%0d: got %b expected 1", s, outValidB); end
         assertCount++; if (outB !== chanB[s]) begin failCount++; $display("[TB] FAIL pad_out_sel%0d: got %h expected %h", s, outB, chanB[s]); end
         assertCount++; if (outSelB !== 2'(s)) begin failCount++; $display("[TB] FAIL pad_outSel_sel%0d: got %0d expected %0d", s, outSelB, s); end
      end
      for (int c = 0; c < 4 + LAT_B - 1; c++) begin
         if (c < 4) applyStimulusB(selTab[c], 1'b1);
         else applyStimulusB(2'd0, 1'b0);
         @(posedge clk); #1;
         if (c >= LAT_B - 1) begin
            assertCount++; if (outB !== chanB[selTab[c-LAT_B+1]]) begin failCount++; $display("[TB] FAIL pad_stream_out[%0d]: got %h expected %h", c-LAT_B+1, outB, chanB[selTab[c-LAT_B+1]]); end
            assertCount++; if (outValidB !== 1'b1) begin failCount++; $display("[TB] FAIL pad_stream_valid[%0d]: got %b expected 1", c-LAT_B+1, outValidB); end
         end
      end
      @(posedge clk);
   endtask

   // A one-clock reset in the middle of a stream clears everything at once.
   task automatic test_reset_mid_stream();
      applyStimulusA(3'd1, 1'b1);
      @(posedge clk);
      applyStimulusA(3'd2, 1'b1);
      @(posedge clk);
      applyStimulusA(3'd3, 1'b1);
      @(posedge clk); #1;
      assertCount++; if (outA !== 8'h22 || outValidA !== 1'b1) begin failCount++; $display("[TB] FAIL mid_prerun: got %h/%b expected 22/1", outA, outValidA); end
      #2;
      rst_n = 1'b0;
      #1;
      assertCount++; if (outA !== 8'h00) begin failCount++; $display("[TB] FAIL mid_rst_out: got %h expected 00", outA); end
      assertCount++; if (outSelA !== 3'd0) begin failCount++; $display("[TB] FAIL mid_rst_outSel: got %0d expected 0", outSelA); end
      assertCount++; if (outValidA !== 1'b0) begin failCount++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", outValidA); end
      applyStimulusA(3'd4, 1'b1);
      @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      selA   = 3'd2;
      validA = 1'b1;
      @(posedge clk); #1;
      assertCount++; if (outValidA !== 1'b0) begin failCount++; $display("[TB] FAIL mid_post_valid1: got %b expected 0", outValidA); end
      assertCount++; if (outA !== 8'h00) begin failCount++; $display("[TB] FAIL mid_post_out1: got %h expected 00", outA); end
      applyStimulusA(3'd0, 1'b0);
      @(posedge clk); #1;
      assertCount++; if (outValidA !== 1'b1) begin failCount++; $display("[TB] FAIL mid_first_valid: got %b expected 1", outValidA); end
      assertCount++; if (outA !== 8'h22) begin failCount++; $display("[TB] FAIL mid_first_out: got %h expected 22", outA); end
      assertCount++; if (outSelA !== 3'd2) begin failCount++; $display("[TB] FAIL mid_first_outSel: got %0d expected 2", outSelA); end
      @(posedge clk); #1;
      assertCount++; if (outValidA !== 1'b0) begin failCount++; $display("[TB] FAIL mid_after_valid: got %b expected 0", outValidA); end
   endtask

   // Scenarios run in order, then one summary line.
   initial begin
      $display("[TB] starting mux_lfmr checks");
      test_reset();
      test_single_select();
      test_sel_sweep();
      test_out_of_range();
      test_valid_bubbles();
      test_back_to_back();
      test_latency_pad();
      test_reset_mid_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
